// File: rtl/if_stage_pkg.sv
// Shared processor constants and types for the instruction-fetch stage.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [63:0] PC_STEP    = 64'd4;
    localparam logic [31:0] HALT_WORD  = 32'h0000_0000;
    localparam logic [63:0] PC_ALIGN_M = {{62{1'b1}}, 2'b00};
    localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;

    // Saturating increment for the capture counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        sat_inc32 = (v == COUNT_MAX) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus: fetch address out, combinational word back.
interface if_stage_if;
    logic [63:0] busPc;
    logic [31:0] instruction;

    modport master (output busPc, input instruction);
    modport slave  (input busPc, output instruction);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with flush > hold > load priority.
module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [63:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [63:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [63:0] pc_d, pc_q;
    logic [31:0] instr_d, instr_q;
    logic        valid_d, valid_q;

    // Next-state selection; a flush only drops valid, payload is kept.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (hold_i) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            valid_d = valid_q;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 64'h0;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, BOOT/RUN/HALT control, IF/ID capture.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    imem,
    input  logic          stall,
    input  logic          redirect,
    input  logic [63:0]   redirect_pc,
    output logic [63:0]   if_id_pc,
    output logic [31:0]   if_id_instr,
    output logic          if_id_valid,
    output logic          halted,
    output logic [31:0]   fetch_count
);

    fetch_state_e state_d, state_q;
    logic [63:0]  pc_d, pc_q;
    logic [31:0]  cnt_d, cnt_q;
    logic         halted_d, halted_q;
    logic         id_load_s, id_hold_s, id_flush_s;
    logic         word_halts_s;

    assign word_halts_s = HALT_ON_ZERO && (imem.instruction == HALT_WORD);

    // Next-state and IF/ID control: redirect beats stall beats state action.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        id_load_s  = 1'b0;
        id_hold_s  = 1'b0;
        id_flush_s = 1'b0;
        if (redirect) begin
            pc_d       = redirect_pc & PC_ALIGN_M;
            id_flush_s = 1'b1;
            state_d    = ST_RUN;
        end else if (stall) begin
            id_hold_s  = 1'b1;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    id_flush_s = 1'b1;
                    state_d    = ST_RUN;
                end
                ST_RUN: begin
                    if (word_halts_s) begin
                        id_flush_s = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        id_load_s  = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                        cnt_d      = sat_inc32(cnt_q);
                    end
                end
                ST_HALT: begin
                    id_flush_s = 1'b1;
                end
                default: begin
                    id_flush_s = 1'b1;
                    state_d    = ST_BOOT;
                end
            endcase
        end
        halted_d = (state_d == ST_HALT);
    end

    // Control and PC state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC & PC_ALIGN_M;
            cnt_q    <= 32'h0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (id_load_s),
        .hold_i  (id_hold_s),
        .flush_i (id_flush_s),
        .pc_i    (pc_q),
        .instr_i (imem.instruction),
        .pc_o    (if_id_pc),
        .instr_o (if_id_instr),
        .valid_o (if_id_valid)
    );

    assign imem.busPc  = pc_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: main instance, wrap-around instance, no-halt instance.
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst3_n, stall, redirect;
    logic [63:0] redirect_pc;
    logic [31:0] mem [0:511];

    int n_cmp = 0;
    int n_err = 0;

    if_stage_if imem1 ();
    if_stage_if imem2 ();
    if_stage_if imem3 ();

    assign imem1.instruction = mem[imem1.busPc[10:2]];
    assign imem2.instruction = mem[imem2.busPc[10:2]];
    assign imem3.instruction = mem[imem3.busPc[10:2]];

    logic [63:0] pc1, pc2, pc3;
    logic [31:0] ins1, ins2, ins3, cnt1, cnt2, cnt3;
    logic        v1, v2, v3, h1, h2, h3;

    if_stage dut1 (
        .clk(clk), .rst_n(rst_n), .imem(imem1), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .if_id_pc(pc1), .if_id_instr(ins1),
        .if_id_valid(v1), .halted(h1), .fetch_count(cnt1)
    );

    if_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem(imem2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(64'h0), .if_id_pc(pc2), .if_id_instr(ins2),
        .if_id_valid(v2), .halted(h2), .fetch_count(cnt2)
    );

    if_stage #(.HALT_ON_ZERO(1'b0)) dut3 (
        .clk(clk), .rst_n(rst3_n), .imem(imem3), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(64'h0), .if_id_pc(pc3), .if_id_instr(ins3),
        .if_id_valid(v3), .halted(h3), .fetch_count(cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'hF840_02A0;
        mem[1] = 32'hF840_02A1;
        mem[2] = 32'h8B00_0023;
        mem[7] = 32'h0000_0000;

        rst_n = 1'b0; rst3_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        step(); step();
        chk("rst_buspc", imem1.busPc, 64'h0);
        chk("rst_pc", pc1, 64'h0);
        chk("rst_instr", ins1, 64'h0);
        chk("rst_valid", v1, 64'h0);
        chk("rst_halted", h1, 64'h0);
        chk("rst_count", cnt1, 64'h0);
        chk("rst_buspc_wrap", imem2.busPc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Startup bubble then 0,4,8 on consecutive cycles.
        rst_n = 1'b1;
        step();
        chk("boot_valid", v1, 64'h0);
        chk("boot_buspc", imem1.busPc, 64'h0);
        step();
        chk("seq0_pc", pc1, 64'h0);
        chk("seq0_instr", ins1, 64'hF840_02A0);
        chk("seq0_valid", v1, 64'h1);
        chk("seq0_count", cnt1, 64'h1);
        chk("wrap_buspc", imem2.busPc, 64'h0);
        chk("wrap_pc", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", ins2, 64'h1000_01FF);
        step();
        chk("seq1_pc", pc1, 64'h4);
        chk("seq1_instr", ins1, 64'hF840_02A1);
        chk("seq1_count", cnt1, 64'h2);
        step();
        chk("seq2_pc", pc1, 64'h8);
        chk("seq2_instr", ins1, 64'h8B00_0023);
        chk("seq2_count", cnt1, 64'h3);
        chk("seq2_buspc", imem1.busPc, 64'hC);

        // Stall two cycles with busPc=0x8 and IF/ID holding the 0x4 capture.
        redirect = 1'b1; redirect_pc = 64'h4;
        step();
        redirect = 1'b0;
        chk("rd4_buspc", imem1.busPc, 64'h4);
        chk("rd4_valid", v1, 64'h0);
        step();
        chk("pre_stall_buspc", imem1.busPc, 64'h8);
        stall = 1'b1;
        step(); step();
        chk("stall_buspc", imem1.busPc, 64'h8);
        chk("stall_pc", pc1, 64'h4);
        chk("stall_instr", ins1, 64'hF840_02A1);
        chk("stall_valid", v1, 64'h1);
        chk("stall_count", cnt1, 64'h4);
        stall = 1'b0;
        step();
        chk("resume_pc", pc1, 64'h8);
        chk("resume_buspc", imem1.busPc, 64'hC);
        chk("resume_count", cnt1, 64'h5);

        // Redirect wins over a simultaneous stall; target is word-aligned.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h13;
        step();
        stall = 1'b0; redirect = 1'b0;
        chk("rd_buspc", imem1.busPc, 64'h10);
        chk("rd_valid", v1, 64'h0);
        chk("rd_count", cnt1, 64'h5);
        step();
        chk("rd_cap_pc", pc1, 64'h10);
        chk("rd_cap_instr", ins1, 64'h1000_0004);
        chk("rd_cap_valid", v1, 64'h1);
        chk("rd_cap_count", cnt1, 64'h6);

        // Zero word at 0x1C halts until a redirect.
        step(); step();
        chk("pre_halt_buspc", imem1.busPc, 64'h1C);
        chk("pre_halt_count", cnt1, 64'h8);
        step();
        chk("halt_halted", h1, 64'h1);
        chk("halt_buspc", imem1.busPc, 64'h1C);
        chk("halt_valid", v1, 64'h0);
        chk("halt_count", cnt1, 64'h8);
        step();
        chk("halt_stay", h1, 64'h1);
        chk("halt_stay_buspc", imem1.busPc, 64'h1C);
        redirect = 1'b1; redirect_pc = 64'h4;
        step();
        redirect = 1'b0;
        chk("unhalt_halted", h1, 64'h0);
        chk("unhalt_buspc", imem1.busPc, 64'h4);
        chk("unhalt_valid", v1, 64'h0);
        step();
        chk("unhalt_cap_pc", pc1, 64'h4);
        chk("unhalt_cap_valid", v1, 64'h1);
        chk("unhalt_cap_count", cnt1, 64'h9);

        // Asynchronous reset mid-run, restart through BOOT.
        rst_n = 1'b0;
        #1;
        chk("arst_buspc", imem1.busPc, 64'h0);
        chk("arst_valid", v1, 64'h0);
        chk("arst_count", cnt1, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rel1_valid", v1, 64'h0);
        step();
        chk("rel2_valid", v1, 64'h1);
        chk("rel2_pc", pc1, 64'h0);
        chk("rel2_count", cnt1, 64'h1);

        // HALT_ON_ZERO=0: the zero word at 0x1C is captured normally.
        rst3_n = 1'b1;
        repeat (9) step();
        chk("nohalt_pc", pc3, 64'h1C);
        chk("nohalt_instr", ins3, 64'h0);
        chk("nohalt_valid", v3, 64'h1);
        chk("nohalt_halted", h3, 64'h0);
        chk("nohalt_buspc", imem3.busPc, 64'h20);
        chk("nohalt_count", cnt3, 64'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC value loaded on reset; bits [1:0] are zero.
REQ-002 SHALL have parameter HALT_ON_ZERO, default 1; when 1, a fetched word of 32'h0 halts fetch.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port busPc, output, 64, the current fetch PC driven to the instruction memory.
REQ-006 SHALL have port instruction, input, 32, the memory word for busPc, returned combinationally in the same cycle.
REQ-007 SHALL have port stall, input, 1, which holds the PC and the IF/ID register.
REQ-008 SHALL have port redirect, input, 1, a taken branch or jump resolved downstream.
REQ-009 SHALL have port redirect_pc, input, 64, the redirect target.
REQ-010 SHALL have port if_id_pc, output, 64, the PC of the captured instruction.
REQ-011 SHALL have port if_id_instr, output, 32, the captured instruction word.
REQ-012 SHALL have port if_id_valid, output, 1, which is 1 when the IF/ID contents are a real instruction.
REQ-013 SHALL have port halted, output, 1, which is 1 while in state HALT.
REQ-014 SHALL have port fetch_count, output, 32, a saturating count of valid captures.

Function
REQ-015 SHALL implement states BOOT, RUN and HALT.
REQ-016 SHALL give evaluation priority per edge in the order reset, redirect, stall, state action.
REQ-017 On redirect, SHALL set PC to {redirect_pc[63:2],2'b00}, clear if_id_valid and enter RUN from any state, even if stall=1.
REQ-018 On stall without redirect, SHALL hold PC, IF/ID, state and fetch_count.
REQ-019 In BOOT, SHALL hold PC, keep if_id_valid=0 and go to RUN; this is a one-bubble startup.
REQ-020 In RUN with a nonzero instruction, SHALL load IF/ID with {busPc, instruction, 1}, set PC to PC+4 and increment fetch_count; latency from PC to if_id_valid is 1 cycle.
REQ-021 In RUN with instruction==0 and HALT_ON_ZERO=1, SHALL clear if_id_valid, hold PC and enter HALT.
REQ-022 With HALT_ON_ZERO=0, SHALL treat a zero word as a normal instruction.
REQ-023 In HALT, SHALL hold PC, keep if_id_valid=0 and drive halted=1; only a redirect or reset exits.
REQ-024 SHALL compute PC+4 modulo 2^64, wrapping from 64'hFFFF_FFFF_FFFF_FFFC to 0.
REQ-025 SHALL let the memory index wrap naturally through busPc[10:2], with no special casing.
REQ-026 SHALL saturate fetch_count at 32'hFFFF_FFFF.
REQ-027 SHALL drive busPc directly from the PC register, with no combinational path from instruction to busPc.

Reset
REQ-028 While rst_n=0, SHALL set busPc=RESET_PC, if_id_pc=0, if_id_instr=0, if_id_valid=0, halted=0, fetch_count=0 and state=BOOT, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight capture; after release the block restarts from BOOT.

Structure
REQ-030 SHALL place the state encoding, PC_STEP=4 and the HALT_WORD=32'h0 constant in the shared processor package.
REQ-031 SHALL implement the IF/ID pipeline register (pc, instr, valid with load, hold and flush controls) as sub-module if_id_reg.

Verification
REQ-032 Reset test: assert rst_n=0 mid-run -> busPc=0, if_id_valid=0, fetch_count=0 immediately; first capture 2 edges after release.
REQ-033 Sequence test: words F84002A0, F84002A1, 8B000023 at PC 0, 4, 8 -> if_id_pc 0, 4, 8 on consecutive cycles with matching if_id_instr and fetch_count 1, 2, 3.
REQ-034 Stall test: stall=1 for 2 cycles at busPc=0x8 -> busPc and if_id stay at 0x8/0x4 contents, then resume at 0xC.
REQ-035 Redirect test: redirect=1 with redirect_pc=0x13 while stall=1 -> next busPc=0x10 and if_id_valid=0, then a capture at 0x10.
REQ-036 Halt test: zero word at 0x1C -> halted=1, busPc stays 0x1C, if_id_valid=0; then redirect_pc=0x4 -> halted=0 and fetch resumes at 0x4.
REQ-037 Wrap test: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> next busPc=0.
